// File: rtl/set_field_control.sv
// Button-driven setter for NUM_TARGETS modulo-MODULUS time fields with
// hold-to-repeat; target 0 also advances on carry_in and produces carry_out.
module set_field_control #(
    parameter int NUM_TARGETS   = 2,
    parameter int WIDTH         = 5,
    parameter int MODULUS       = 24,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100,
    localparam int SEL_W        = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
    input  logic                         ck,
    input  logic                         reset,
    input  logic                         btn,
    input  logic [SEL_W-1:0]             sel,
    input  logic                         carry_in,
    output logic [NUM_TARGETS-1:0]       up,
    output logic [NUM_TARGETS*WIDTH-1:0] value,
    output logic                         carry_out
);

    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, FIRST, HOLD, REPEAT} state_t;

    state_t             state, state_d;
    logic [TW-1:0]      timer, timer_d;
    logic [SEL_W-1:0]   tsel;
    logic               tsel_ok;
    logic               released;
    logic               load_sel;
    logic               manual;
    logic               sel_ok;
    logic [NUM_TARGETS-1:0] step;
    logic [WIDTH-1:0]   vals   [NUM_TARGETS];
    logic [WIDTH-1:0]   vals_d [NUM_TARGETS];

    function automatic logic [WIDTH-1:0] bump(input logic [WIDTH-1:0] v, input logic [1:0] inc);
        logic [WIDTH:0] s;
        s = {1'b0, v} + (WIDTH+1)'(inc);
        if (s >= (WIDTH+1)'(MODULUS))
            s = s - (WIDTH+1)'(MODULUS);
        return s[WIDTH-1:0];
    endfunction

    assign sel_ok = ({1'b0, sel} < (SEL_W+1)'(NUM_TARGETS));

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d  = state;
        timer_d  = timer;
        load_sel = 1'b0;
        manual   = 1'b0;
        case (state)
            IDLE: begin
                timer_d = '0;
                if (btn && released) begin
                    state_d  = FIRST;
                    load_sel = 1'b1;
                end
            end
            FIRST: begin
                manual  = 1'b1;
                timer_d = '0;
                state_d = btn ? HOLD : IDLE;
            end
            HOLD: begin
                if (!btn) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (REPEAT_DELAY > 0) begin
                    if (timer == TW'(REPEAT_DELAY - 1)) begin
                        state_d = REPEAT;
                        timer_d = '0;
                    end else begin
                        timer_d = timer + TW'(1);
                    end
                end
            end
            REPEAT: begin
                manual = (timer == '0);
                if (!btn) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer == TW'(REPEAT_PERIOD - 1)) begin
                    timer_d = '0;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Carry step on target 0 is applied alongside any manual step in the same cycle.
    always_comb begin
        for (int i = 0; i < NUM_TARGETS; i++) begin
            step[i]   = manual && tsel_ok && (tsel == SEL_W'(i));
            up[i]     = step[i] || ((i == 0) && carry_in);
            vals_d[i] = bump(vals[i], 2'(step[i]) + ((i == 0) ? 2'(carry_in) : 2'd0));
            value[i*WIDTH +: WIDTH] = vals[i];
        end
    end

    assign carry_out = carry_in && (vals[0] == WIDTH'(MODULUS - 1));

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            timer    <= '0;
            tsel     <= '0;
            tsel_ok  <= 1'b0;
            released <= 1'b0;
            for (int i = 0; i < NUM_TARGETS; i++)
                vals[i] <= '0;
        end else begin
            state    <= state_d;
            timer    <= timer_d;
            // A button held through reset must be released before it can step.
            released <= released | ~btn;
            if (load_sel) begin
                tsel    <= sel;
                tsel_ok <= sel_ok;
            end
            for (int i = 0; i < NUM_TARGETS; i++)
                vals[i] <= vals_d[i];
        end
    end

endmodule
